// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary GCD engine.
package gcd_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_SUB    = 2'd2,
    ST_DONE   = 2'd3
  } gcd_state_e;

  // Datapath operation selected by the controller each cycle
  typedef enum logic [2:0] {
    DP_HOLD       = 3'd0,
    DP_LOAD       = 3'd1,
    DP_HALVE_BOTH = 3'd2,
    DP_HALVE_A    = 3'd3,
    DP_HALVE_B    = 3'd4,
    DP_SUB_AB     = 3'd5,
    DP_SUB_BA     = 3'd6
  } dp_op_e;

  // Bits needed to hold values 0 .. v-1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/gcd_bin_dp.sv
// Binary GCD datapath: operand registers, common-shift counter, compare/subtract/shift.
module gcd_bin_dp
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  dp_op_e           op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             a_even,
  output logic             b_even,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic [WIDTH-1:0] result_c
);

  localparam int unsigned KW = clog2(WIDTH + 1);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  // Status flags and difference terms for the controller
  always_comb begin
    a_even    = ~a[0];
    b_even    = ~b[0];
    a_eq_b    = (a == b);
    a_gt_b    = (a > b);
    a_minus_b = a - b;
    b_minus_a = b - a;
    result_c  = a << k;
  end

  // Operand and shift-count registers updated by the selected operation
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      k <= '0;
    end else begin
      case (op)
        DP_LOAD: begin
          a <= in_a;
          b <= in_b;
          k <= '0;
        end
        DP_HALVE_BOTH: begin
          a <= a >> 1;
          b <= b >> 1;
          k <= k + KW'(1);
        end
        DP_HALVE_A: a <= a >> 1;
        DP_HALVE_B: b <= b >> 1;
        DP_SUB_AB:  a <= a_minus_b >> 1;
        DP_SUB_BA:  b <= b_minus_a >> 1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Stein GCD engine with valid/ready handshakes and a saturating cycle count.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_cycles
);

  gcd_state_e       state;
  gcd_state_e       state_nxt;
  dp_op_e           op;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             out_valid_nxt;
  logic [WIDTH-1:0] out_gcd_nxt;
  logic [CNT_W-1:0] out_cycles_nxt;
  logic             a_even;
  logic             b_even;
  logic             a_eq_b;
  logic             a_gt_b;
  logic [WIDTH-1:0] result_c;

  // Ready is forced low while reset is asserted
  assign in_ready = (state == ST_IDLE) && !rst;

  gcd_bin_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .in_a     (in_a),
    .in_b     (in_b),
    .a_even   (a_even),
    .b_even   (b_even),
    .a_eq_b   (a_eq_b),
    .a_gt_b   (a_gt_b),
    .result_c (result_c)
  );

  // Next-state, datapath op and result capture
  always_comb begin
    state_nxt      = state;
    op             = DP_HOLD;
    cnt_nxt        = cnt;
    out_valid_nxt  = out_valid;
    out_gcd_nxt    = out_gcd;
    out_cycles_nxt = out_cycles;
    cnt_inc        = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          op      = DP_LOAD;
          cnt_nxt = '0;
          if ((in_a == '0) || (in_b == '0)) begin
            state_nxt      = ST_DONE;
            out_valid_nxt  = 1'b1;
            out_gcd_nxt    = in_a | in_b;
            out_cycles_nxt = '0;
          end else begin
            state_nxt = ST_REDUCE;
          end
        end
      end
      ST_REDUCE: begin
        cnt_nxt = cnt_inc;
        if (a_even && b_even) op = DP_HALVE_BOTH;
        else                  state_nxt = ST_SUB;
      end
      ST_SUB: begin
        cnt_nxt = cnt_inc;
        if (a_even)      op = DP_HALVE_A;
        else if (b_even) op = DP_HALVE_B;
        else if (a_eq_b) begin
          state_nxt      = ST_DONE;
          out_valid_nxt  = 1'b1;
          out_gcd_nxt    = result_c;
          out_cycles_nxt = cnt_inc;
        end
        else if (a_gt_b) op = DP_SUB_AB;
        else             op = DP_SUB_BA;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_gcd    <= '0;
      out_cycles <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_valid  <= out_valid_nxt;
      out_gcd    <= out_gcd_nxt;
      out_cycles <= out_cycles_nxt;
    end
  end

endmodule
